frame_dispatcher: RTL

- Downstream consumer of the frame FIFO written by the frame parser.
- Pops one 140-bit entry, checks it, then serialises the payload as 16-bit words onto the channel bus.
- Drives the words to every channel set in the entry's channel mask, under a ready/valid handshake with the output stage.
- Sits between the frame FIFO and the per-channel output logic.

---
 rtl/frame_pkg.sv | 19 +
 rtl/frame_dispatcher.sv | 95 +++++++++
 2 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: frame FIFO entry layout (payload[139:12], ch_sel[11:4], len[3:0]), dispatcher constants, state enum, entry check
package frame_pkg;
  localparam int CH_NUM = 8;
  localparam int WORD_W = 16;
  localparam int MAX_WORDS = 8;
  localparam int PAY_MSB = 139;
  localparam int PAY_LSB = 12;
  localparam int CH_MSB = 11;
  localparam int CH_LSB = 4;
  localparam int LEN_MSB = 3;
  localparam int LEN_LSB = 0;
  localparam int ENTRY_W = PAY_MSB + 1;
  localparam int PAY_W = PAY_MSB - PAY_LSB + 1;
  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} disp_state_t;
  function automatic logic entry_ok(logic [LEN_W-1:0] len, logic [CH_NUM-1:0] ch);
    return (len != '0) && (len <= LEN_W'(MAX_WORDS)) && (|ch);
  endfunction
endpackage

// File: rtl/frame_dispatcher.sv
// frame_dispatcher: pops frame FIFO entries (fifo_empty/fifo_r_enable/data_from_fifo), streams payload words on data_out/ch_valid under out_ready, pulses frame_done/ch_err
module frame_dispatcher
  import frame_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_r_enable,
  input  logic [ENTRY_W-1:0] data_from_fifo,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  data_out,
  output logic [CH_NUM-1:0]  ch_valid,
  output logic               frame_done,
  output logic               ch_err
);
  disp_state_t state_q, state_d;
  logic [PAY_W-1:0] pay_q, pay_d;
  logic [CH_NUM-1:0] mask_q, mask_d, ch_valid_q, ch_valid_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic frame_done_q, frame_done_d, ch_err_q, ch_err_d;
  logic [PAY_W-1:0] fifo_pay;
  logic [CH_NUM-1:0] fifo_ch;
  logic [LEN_W-1:0] fifo_len;
  logic ok, last;
  assign fifo_pay = data_from_fifo[PAY_MSB:PAY_LSB];
  assign fifo_ch = data_from_fifo[CH_MSB:CH_LSB];
  assign fifo_len = data_from_fifo[LEN_MSB:LEN_LSB];
  assign ok = entry_ok(fifo_len, fifo_ch);
  assign last = cnt_q == len_q;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pay_q <= '0;
      mask_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      data_out_q <= '0;
      ch_valid_q <= '0;
      frame_done_q <= 1'b0;
      ch_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pay_q <= pay_d;
      mask_q <= mask_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      data_out_q <= data_out_d;
      ch_valid_q <= ch_valid_d;
      frame_done_q <= frame_done_d;
      ch_err_q <= ch_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fifo_empty ? IDLE : FETCH;
      FETCH:   state_d = ok ? SEND : IDLE;
      SEND:    state_d = (out_ready && last) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pay_d = pay_q;
    mask_d = mask_q;
    len_d = len_q;
    cnt_d = cnt_q;
    data_out_d = data_out_q;
    ch_valid_d = ch_valid_q;
    frame_done_d = 1'b0;
    ch_err_d = 1'b0;
    if (state_q == FETCH) begin
      pay_d = fifo_pay << WORD_W;
      mask_d = fifo_ch;
      len_d = fifo_len;
      ch_err_d = !ok;
      data_out_d = ok ? fifo_pay[PAY_W-1 -: WORD_W] : data_out_q;
      ch_valid_d = ok ? fifo_ch : ch_valid_q;
      cnt_d = ok ? LEN_W'(1) : cnt_q;
    end else if (state_q == SEND && out_ready) begin
      pay_d = last ? pay_q : pay_q << WORD_W;
      data_out_d = last ? '0 : pay_q[PAY_W-1 -: WORD_W];
      ch_valid_d = last ? '0 : mask_q;
      cnt_d = last ? cnt_q : cnt_q + LEN_W'(1);
      frame_done_d = last;
    end
  end
  always_comb begin
    fifo_r_enable = (state_q == IDLE) && !fifo_empty && rst_n;
    data_out = data_out_q;
    ch_valid = ch_valid_q;
    frame_done = frame_done_q;
    ch_err = ch_err_q;
  end
endmodule
